// File: rtl/ot_pkg.sv
// Shared types for the output write-back path.
// State encoding, width defaults and the per-layer config bundle.
package ot_pkg;

  localparam int OT_TBITS = 64;
  localparam int OT_CNT_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } ot_state_e;

  typedef struct packed {
    logic [OT_CNT_W-1:0] words_per_col;
    logic [OT_CNT_W-1:0] num_cols;
  } ot_cfg_t;

endpackage

// File: rtl/ot_out_reg.sv
// Single-entry valid/ready output stage holding a data word and its last flag.
// Ports: load/d/d_last in, q/q_last/valid out, ready from downstream.
module ot_out_reg #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         d_last,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] q,
  output logic         q_last
);

  // A load always wins, so an accept plus a pop in one cycle
  // refills the register without a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid  <= 1'b0;
      q      <= '0;
      q_last <= 1'b0;
    end else if (load) begin
      valid  <= 1'b1;
      q      <= d;
      q_last <= d_last;
    end else if (ready) begin
      valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/ot_drain_ctrl.sv
// Write-back scheduler: drains the output FIFO onto a valid/ready stream,
// marks column ends with m_tlast, pulses done at layer end. cfg_* configure.
module ot_drain_ctrl
  import ot_pkg::*;
#(
  parameter int TBITS = OT_TBITS,
  parameter int CNT_W = OT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_start,
  input  logic [CNT_W-1:0] cfg_words_per_col,
  input  logic [CNT_W-1:0] cfg_num_cols,
  input  logic             fifo_empty_n,
  input  logic [TBITS-1:0] fifo_data,
  input  logic             fifo_error,
  output logic             fifo_read,
  output logic [TBITS-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic [CNT_W-1:0] col_idx
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_RUN   = ST_RUN;
  localparam logic [1:0] S_FLUSH = ST_FLUSH;
  localparam logic [1:0] S_DONE  = ST_DONE;

  logic [1:0]       state;
  ot_cfg_t          cfg_q;
  logic [CNT_W-1:0] word_cnt;
  logic             last_w;
  logic             last_c;
  logic             cfg_zero;

  assign cfg_zero = (cfg_words_per_col == '0) |
                    (cfg_num_cols == '0);

  assign last_w = word_cnt ==
                  cfg_q.words_per_col - CNT_W'(1);
  assign last_c = col_idx ==
                  cfg_q.num_cols - CNT_W'(1);

  assign fifo_read = (state == S_RUN) & fifo_empty_n &
                     (~m_tvalid | m_tready);

  assign busy = (state == S_RUN) | (state == S_FLUSH);
  assign done = (state == S_DONE);

  ot_out_reg #(
    .W (TBITS)
  ) u_out (
    .clk    (clk),
    .reset  (reset),
    .load   (fifo_read),
    .d      (fifo_data),
    .d_last (last_w),
    .ready  (m_tready),
    .valid  (m_tvalid),
    .q      (m_tdata),
    .q_last (m_tlast)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cfg_q    <= '0;
      word_cnt <= '0;
      col_idx  <= '0;
      cfg_err  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cfg_start) begin
            if (cfg_zero) begin
              cfg_err <= 1'b1;
              state   <= S_DONE;
            end else begin
              cfg_q.words_per_col <= cfg_words_per_col;
              cfg_q.num_cols      <= cfg_num_cols;
              word_cnt <= '0;
              col_idx  <= '0;
              cfg_err  <= 1'b0;
              state    <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (fifo_read) begin
            if (last_w) begin
              word_cnt <= '0;
              // Column counter parks on the last column at layer end.
              if (last_c) state <= S_FLUSH;
              else col_idx <= col_idx + CNT_W'(1);
            end else begin
              word_cnt <= word_cnt + CNT_W'(1);
            end
          end
        end
        S_FLUSH: begin
          if (m_tvalid & m_tready) state <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      // Overflow alarm is sticky and outranks a clearing start.
      if (fifo_error) cfg_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ot_drain_ctrl.sv
// Self-checking bench for ot_drain_ctrl.
// Emulated FIFO queue plus a reference list of expected beats per layer.
module tb_ot_drain_ctrl;

  localparam int TB = 64;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_start;
  logic [CW-1:0] cfg_words_per_col;
  logic [CW-1:0] cfg_num_cols;
  logic          fifo_empty_n;
  logic [TB-1:0] fifo_data;
  logic          fifo_error;
  logic          fifo_read;
  logic [TB-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic          busy;
  logic          done;
  logic          cfg_err;
  logic [CW-1:0] col_idx;

  always #5 clk = ~clk;

  ot_drain_ctrl #(
    .TBITS (TB),
    .CNT_W (CW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .cfg_start         (cfg_start),
    .cfg_words_per_col (cfg_words_per_col),
    .cfg_num_cols      (cfg_num_cols),
    .fifo_empty_n      (fifo_empty_n),
    .fifo_data         (fifo_data),
    .fifo_error        (fifo_error),
    .fifo_read         (fifo_read),
    .m_tdata           (m_tdata),
    .m_tvalid          (m_tvalid),
    .m_tready          (m_tready),
    .m_tlast           (m_tlast),
    .busy              (busy),
    .done              (done),
    .cfg_err           (cfg_err),
    .col_idx           (col_idx)
  );

  logic [TB-1:0] fq[$];
  bit            starve;
  int            checks = 0;
  int            errors = 0;

  logic          o_read, o_valid, o_last;
  logic          o_busy, o_done, o_err;
  logic [TB-1:0] o_data;
  logic [CW-1:0] o_col;

  // Drive the FIFO model, sample outputs mid-cycle, advance one clock.
  task automatic tick();
    fifo_empty_n = (fq.size() != 0) && !starve;
    fifo_data    = (fq.size() != 0) ? fq[0] : '0;
    #1;
    o_read  = fifo_read;
    o_valid = m_tvalid;
    o_data  = m_tdata;
    o_last  = m_tlast;
    o_busy  = busy;
    o_done  = done;
    o_err   = cfg_err;
    o_col   = col_idx;
    @(posedge clk);
    if (o_read && fq.size() != 0) void'(fq.pop_front());
    @(negedge clk);
    fifo_empty_n = (fq.size() != 0) && !starve;
    fifo_data    = (fq.size() != 0) ? fq[0] : '0;
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) fq.push_back({$urandom, $urandom});
  endtask

  // mode 0: ready high; 1: ready 1,0,0,1; 2: starve 4 cycles;
  // 3: random ready and random starve.
  task automatic run_layer(input int w, input int c,
                           input int mode, input int ferr_at);
    logic [TB-1:0] exp_d[$];
    bit            exp_l[$];
    int            beat, pops;
    bit            seen_done;
    bit            pv, pr, prd, ev;
    logic [TB-1:0] pd;
    logic          pl;
    for (int i = 0; i < w * c; i++) begin
      exp_d.push_back(fq[i]);
      exp_l.push_back((i % w) == (w - 1));
    end
    beat = 0; pops = 0; seen_done = 0;
    cfg_words_per_col = CW'(w);
    cfg_num_cols      = CW'(c);
    cfg_start = 1'b1;
    m_tready  = 1'b1;
    tick();
    cfg_start = 1'b0;
    pv = o_valid; pr = m_tready; prd = o_read;
    pd = o_data;  pl = o_last;
    for (int k = 1; k < 400 && !seen_done; k++) begin
      case (mode)
        1:       m_tready = (k % 4 == 0) || (k % 4 == 3);
        3:       m_tready = ($urandom % 4) != 0;
        default: m_tready = 1'b1;
      endcase
      if (mode == 2)      starve = (k >= 2 && k <= 5);
      else if (mode == 3) starve = ($urandom % 5) == 0;
      else                starve = 1'b0;
      fifo_error = (k == ferr_at);
      tick();
      if (k == 1) begin
        checks++;
        if (o_err !== 1'b0) begin
          errors++;
          $display("FAIL err_clear_on_start got %0b want 0", o_err);
        end
        if (mode == 0) begin
          checks++;
          if (o_read !== 1'b1) begin
            errors++;
            $display("FAIL first_pop_n1 got %0b want 1", o_read);
          end
        end
      end
      ev = prd | (pv & ~pr);
      checks++;
      if (o_valid !== ev) begin
        errors++;
        $display("FAIL tvalid k=%0d got %0b want %0b", k, o_valid, ev);
      end
      if (pv && !pr) begin
        checks++;
        if (o_data !== pd || o_last !== pl) begin
          errors++;
          $display("FAIL stall_stable k=%0d got %h/%0b want %h/%0b",
                   k, o_data, o_last, pd, pl);
        end
      end
      checks++;
      if (o_read && o_valid && !m_tready) begin
        errors++;
        $display("FAIL pop_in_stall k=%0d got read=1 want 0", k);
      end
      if (mode == 2 && k >= 2 && k <= 5) begin
        checks++;
        if (o_col !== '0 || o_read !== 1'b0) begin
          errors++;
          $display("FAIL starve_hold k=%0d got col=%0d read=%0b want 0/0",
                   k, o_col, o_read);
        end
      end
      if (o_read) pops++;
      if (o_valid && m_tready) begin
        checks++;
        if (beat >= exp_d.size()) begin
          errors++;
          $display("FAIL extra_beat got beat %0d want %0d beats",
                   beat, exp_d.size());
        end else if (o_data !== exp_d[beat] || o_last !== exp_l[beat]) begin
          errors++;
          $display("FAIL beat%0d got %h/%0b want %h/%0b", beat,
                   o_data, o_last, exp_d[beat], exp_l[beat]);
        end
        beat++;
      end
      if (o_done) begin
        seen_done = 1;
        checks++;
        if (beat != w * c || pops != w * c || o_busy !== 1'b0) begin
          errors++;
          $display("FAIL done_counts got beats=%0d pops=%0d busy=%0b want %0d/%0d/0",
                   beat, pops, o_busy, w * c, w * c);
        end
        if (mode == 0) begin
          checks++;
          if (k != w * c + 2) begin
            errors++;
            $display("FAIL done_latency got %0d want %0d", k, w * c + 2);
          end
        end
      end else begin
        checks++;
        if (o_busy !== 1'b1) begin
          errors++;
          $display("FAIL busy k=%0d got %0b want 1", k, o_busy);
        end
      end
      pv = o_valid; pr = m_tready; prd = o_read;
      pd = o_data;  pl = o_last;
    end
    fifo_error = 1'b0;
    starve     = 1'b0;
    m_tready   = 1'b1;
    checks++;
    if (!seen_done) begin
      errors++;
      $display("FAIL done_timeout got no done want done");
    end
    checks++;
    if (o_col !== CW'(c - 1)) begin
      errors++;
      $display("FAIL col_idx_end got %0d want %0d", o_col, c - 1);
    end
    tick();
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0 || o_read !== 1'b0 ||
        o_valid !== 1'b0 || o_err !== (ferr_at > 0)) begin
      errors++;
      $display("FAIL post_done got d=%0b b=%0b r=%0b v=%0b e=%0b want 0/0/0/0/%0b",
               o_done, o_busy, o_read, o_valid, o_err, ferr_at > 0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (o_read !== 0 || o_valid !== 0 || o_data !== '0 || o_last !== 0 ||
        o_busy !== 0 || o_done !== 0 || o_err !== 0 || o_col !== '0) begin
      errors++;
      $display("FAIL reset_state got r%0b v%0b d%h l%0b b%0b dn%0b e%0b c%0d want zeros",
               o_read, o_valid, o_data, o_last, o_busy, o_done, o_err, o_col);
    end
  endtask

  task automatic test_basic();
    for (int i = 1; i <= 6; i++) fq.push_back(64'hA5A5_0000_0000_0000 | 64'(i));
    run_layer(3, 2, 0, 0);
  endtask

  task automatic test_backpressure();
    fq.delete();
    fill_rand(6);
    run_layer(3, 2, 1, 0);
  endtask

  task automatic test_starved_fifo();
    fq.delete();
    fill_rand(6);
    run_layer(3, 2, 2, 0);
  endtask

  task automatic test_zero_config();
    fq.delete();
    fill_rand(2);
    cfg_words_per_col = '0;
    cfg_num_cols      = CW'(5);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    tick();
    checks++;
    if (o_done !== 1 || o_err !== 1 || o_busy !== 0 ||
        o_read !== 0 || o_valid !== 0) begin
      errors++;
      $display("FAIL zero_cfg got dn%0b e%0b b%0b r%0b v%0b want 1/1/0/0/0",
               o_done, o_err, o_busy, o_read, o_valid);
    end
    tick();
    checks++;
    if (o_done !== 0 || o_err !== 1 || o_read !== 0 || o_valid !== 0) begin
      errors++;
      $display("FAIL zero_cfg_after got dn%0b e%0b r%0b v%0b want 0/1/0/0",
               o_done, o_err, o_read, o_valid);
    end
    run_layer(2, 1, 0, 0);
  endtask

  task automatic test_error_and_reset();
    fq.delete();
    fill_rand(6);
    run_layer(3, 2, 0, 3);
    fq.delete();
    fill_rand(6);
    cfg_words_per_col = CW'(3);
    cfg_num_cols      = CW'(2);
    cfg_start = 1'b1;
    m_tready  = 1'b1;
    tick();
    cfg_start = 1'b0;
    tick();
    tick();
    reset     = 1'b1;
    cfg_start = 1'b1;
    tick();
    reset     = 1'b0;
    cfg_start = 1'b0;
    tick();
    checks++;
    if (o_read !== 0 || o_valid !== 0 || o_data !== '0 || o_last !== 0 ||
        o_busy !== 0 || o_done !== 0 || o_err !== 0 || o_col !== '0) begin
      errors++;
      $display("FAIL mid_reset got r%0b v%0b d%h l%0b b%0b dn%0b e%0b c%0d want zeros",
               o_read, o_valid, o_data, o_last, o_busy, o_done, o_err, o_col);
    end
    tick();
    checks++;
    if (o_busy !== 0 || o_read !== 0) begin
      errors++;
      $display("FAIL start_in_reset got busy=%0b read=%0b want 0/0",
               o_busy, o_read);
    end
  endtask

  task automatic test_surplus();
    fq.delete();
    fill_rand(8);
    run_layer(2, 3, 0, 0);
    checks++;
    if (fq.size() != 2 || fifo_empty_n !== 1'b1) begin
      errors++;
      $display("FAIL surplus got left=%0d empty_n=%0b want 2/1",
               fq.size(), fifo_empty_n);
    end
  endtask

  task automatic test_random();
    int w, c;
    for (int it = 0; it < 6; it++) begin
      fq.delete();
      w = $urandom_range(1, 4);
      c = $urandom_range(1, 4);
      fill_rand(w * c + $urandom_range(0, 2));
      run_layer(w, c, 3, 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    cfg_start = 1'b0;
    cfg_words_per_col = '0;
    cfg_num_cols = '0;
    fifo_empty_n = 1'b0;
    fifo_data = '0;
    fifo_error = 1'b0;
    m_tready = 1'b1;
    starve = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_starved_fifo();
    test_zero_config();
    test_error_and_reset();
    test_surplus();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ot_drain_ctrl.md
# ot_drain_ctrl

Write-back scheduler for the output path. It drains 64-bit packed output words from the output FIFO (fed by the quantized-byte packer) and sequences them onto a ready/valid stream toward the output buffer/DMA. It counts words per column and columns per layer, marks each column end with `m_tlast`, and reports layer completion. It sits between the output FIFO and the output write master, and is configured per layer by the top-level controller.

## Interface
**Parameters**
- `TBITS`, 64: data word width.
- `CNT_W`, 12: width of the word and column counters and config fields.

**Ports**
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `cfg_start`, in, 1: one-cycle start pulse. Latches the config fields.
- `cfg_words_per_col`, in, CNT_W: 64-bit words per column. 0 is illegal.
- `cfg_num_cols`, in, CNT_W: columns per layer. 0 is illegal.
- `fifo_empty_n`, in, 1: FIFO holds data (first-word fall-through).
- `fifo_data`, in, TBITS: FIFO head word, valid while `fifo_empty_n` is high.
- `fifo_error`, in, 1: FIFO overflow alarm.
- `fifo_read`, out, 1: pop the FIFO head this cycle.
- `m_tdata`, out, TBITS: output word.
- `m_tvalid`, out, 1: output valid.
- `m_tready`, in, 1: downstream accept.
- `m_tlast`, out, 1: last word of a column.
- `busy`, out, 1: high from the cycle after `cfg_start` until `done`.
- `done`, out, 1: one-cycle layer-complete pulse.
- `cfg_err`, out, 1: sticky. Set on a zero config or on `fifo_error`.
- `col_idx`, out, CNT_W: index of the column currently being emitted.

## Operation
**States**
- IDLE
  - On `cfg_start` with both config fields nonzero: latch config, clear counters, go to RUN.
  - On `cfg_start` with either field zero: set `cfg_err`, go to DONE. No words move.
  - `cfg_start` is ignored in every other state.
- RUN
  - `fifo_read = fifo_empty_n & (~m_tvalid | m_tready)`.
  - A single output register loads `fifo_data` on `fifo_read`.
  - `m_tlast` is registered with the data word; it is 1 when `word_cnt == words_per_col-1`.
  - `word_cnt` increments on each pop and wraps to 0 after the last word of a column. `col_idx` then increments.
  - The pop of the last word of the last column moves the FSM to FLUSH. No further pops occur.
- FLUSH
  - Holds `m_tvalid`/`m_tdata`/`m_tlast` stable until `m_tready`.
  - On the handshake: go to DONE.
- DONE
  - `done=1` for one cycle, then IDLE.
  - `busy=0` in DONE.

**Rules**
- Handshake: `m_tdata`/`m_tlast` must not change while `m_tvalid & ~m_tready`.
- `m_tvalid` drops only after a handshake when no new word is popped.
- `fifo_error` during any state sets `cfg_err`. Draining continues. `cfg_err` clears only on `reset` or the next accepted valid `cfg_start`.
- Extra FIFO words beyond `words_per_col*num_cols` are left in the FIFO.
- Reset mid-operation returns to IDLE with the output register invalidated. The FIFO is not flushed by this block.
- Counter arithmetic is CNT_W unsigned. `words_per_col*num_cols` is never computed; two nested counters are used instead.

**Reset values**
- `fifo_read=0`, `m_tvalid=0`, `m_tdata=0`, `m_tlast=0`, `busy=0`, `done=0`, `cfg_err=0`, `col_idx=0`, state IDLE.

## Timing
- `cfg_start` at cycle N: `busy=1` at N+1. The first `fifo_read` is possible at N+1.
- `fifo_read` at cycle K: `m_tvalid`/`m_tdata` are valid at K+1.
- Throughput is 1 word/cycle with `m_tready` held high and the FIFO non-empty.
- Simultaneous accept and pop: the register reloads in the same cycle without a bubble.
- Layer of W×C words with no stalls: `done` arrives W·C+2 cycles after `cfg_start`. That is the last pop at N+W·C, its handshake at N+W·C+1, and DONE at N+W·C+2.
- `fifo_read` is purely combinational from `fifo_empty_n`, `m_tvalid`, `m_tready` and state.

## Structure
- Shared package `ot_pkg`:
  - `ot_state_e` (IDLE, RUN, FLUSH, DONE).
  - `TBITS`, `CNT_W` defaults.
  - `ot_cfg_t` struct (`words_per_col`, `num_cols`).
- One natural sub-module, `ot_out_reg`: a single-entry valid/ready output stage holding data and last. The FSM and counters stay in `ot_drain_ctrl`.

## Test plan
- **Basic layer:** W=3, C=2, FIFO preloaded with 0x…01..0x…06, `m_tready=1`.
  - 6 words in order.
  - `m_tlast` on words 3 and 6.
  - `col_idx` goes 0→1.
  - `done` at N+8.
  - No extra `fifo_read`.
- **Backpressure:** same layer, `m_tready` toggled 1,0,0,1,…
  - Data and `m_tlast` stable during stalls.
  - No pop while `m_tvalid & ~m_tready`.
  - All 6 words are delivered exactly once.
- **Starved FIFO:** `fifo_empty_n` low for 4 cycles mid-column 0.
  - `m_tvalid` drops after the pending handshake.
  - Counters hold.
  - Completion is correct with W=3, C=2.
- **Zero config:** `cfg_start` with W=0, C=5.
  - `cfg_err=1` and `done` pulse.
  - No `fifo_read`, `m_tvalid` stays 0.
  - A following valid start (W=2, C=1) clears `cfg_err` and runs normally.
- **Error and reset:**
  - `fifo_error` pulse during RUN: `cfg_err` stays 1 and the layer still completes.
  - `reset` asserted mid-column: next cycle all outputs are at reset values, state IDLE, and a `cfg_start` in the reset cycle is ignored.
- **Surplus data:** 8 words queued, W=2, C=3.
  - Exactly 6 pops occur.
  - `fifo_empty_n` is still 1 after `done`.
